unidade_controle_drone: RTL and testbench

- Moore FSM that sequences the drone game datapath (fluxo_dados).
- Drives position reset, shift and the move-timer controls, and waits for the synchronous map read before sampling colisao.
- Tracks remaining lives and reports win/lose.
- Sits beside fluxo_dados inside the top-level game module. Steering input controle goes straight to the datapath and never passes through this block.

---
 rtl/unidade_controle_drone.sv | 127 ++++++++++++
 tb/tb_unidade_controle_drone.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_drone.sv
// Control unit for the drone game: sequences the datapath through move
// cycles, samples collisions after the synchronous map read, tracks lives
// and reports win/lose.
module unidade_controle_drone #(
  parameter int unsigned VIDAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pausa,
  input  logic       colisao,
  input  logic       fim_espera,
  input  logic       fim_mapa,
  output logic       zeraPosicoes,
  output logic       desloca,
  output logic       contaT,
  output logic       zeraT,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [1:0] db_vidas,
  output logic [3:0] db_estado
);

  localparam int unsigned EW = 4;
  localparam int unsigned VW = 2;
  localparam logic [VW-1:0] VIDAS_INI = VW'(VIDAS);

  typedef enum logic [EW-1:0] {
    INICIAL    = 4'd0,
    PREPARACAO = 4'd1,
    ESPERA     = 4'd2,
    DESLOCA    = 4'd3,
    CARREGA    = 4'd4,
    VERIFICA   = 4'd5,
    VITORIA    = 4'd6,
    DERROTA    = 4'd7,
    PAUSADO    = 4'd8
  } estado_t;

  // Held as a plain vector so the unused codes 9..15 stay representable
  // and recover to INICIAL through the default branch.
  logic [EW-1:0] estado_q;
  logic [EW-1:0] estado_n;
  logic [VW-1:0] vidas_q;
  logic [VW-1:0] vidas_n;

  // Next-state and next-lives selection.
  always_comb begin
    estado_n = estado_q;
    vidas_n  = vidas_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          estado_n = PREPARACAO;
          vidas_n  = VIDAS_INI;
        end
      end
      PREPARACAO: estado_n = ESPERA;
      ESPERA: begin
        if (pausa) begin
          estado_n = PAUSADO;
        end else if (fim_espera) begin
          estado_n = DESLOCA;
        end
      end
      PAUSADO: begin
        if (pausa) begin
          estado_n = ESPERA;
        end
      end
      DESLOCA: estado_n = CARREGA;
      CARREGA: estado_n = VERIFICA;
      VERIFICA: begin
        // Collision takes priority over reaching the end of the map.
        if (colisao && (vidas_q > VW'(1))) begin
          estado_n = PREPARACAO;
          vidas_n  = vidas_q - VW'(1);
        end else if (colisao) begin
          estado_n = DERROTA;
          vidas_n  = '0;
        end else if (fim_mapa) begin
          estado_n = VITORIA;
        end else begin
          estado_n = ESPERA;
        end
      end
      VITORIA, DERROTA: begin
        if (iniciar) begin
          estado_n = PREPARACAO;
          vidas_n  = VIDAS_INI;
        end
      end
      default: estado_n = INICIAL;
    endcase
  end

  // State, lives and output registers; outputs are decoded from the state
  // being entered so they line up cycle-for-cycle with db_estado.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= INICIAL;
      vidas_q      <= VIDAS_INI;
      zeraPosicoes <= 1'b0;
      desloca      <= 1'b0;
      contaT       <= 1'b0;
      zeraT        <= 1'b0;
      pronto       <= 1'b0;
      ganhou       <= 1'b0;
      perdeu       <= 1'b0;
    end else begin
      estado_q     <= estado_n;
      vidas_q      <= vidas_n;
      zeraPosicoes <= (estado_n == PREPARACAO);
      desloca      <= (estado_n == DESLOCA);
      contaT       <= (estado_n == ESPERA);
      zeraT        <= (estado_n == PREPARACAO) || (estado_n == VERIFICA);
      pronto       <= (estado_n == VITORIA) || (estado_n == DERROTA);
      ganhou       <= (estado_n == VITORIA);
      perdeu       <= (estado_n == DERROTA);
    end
  end

  assign db_estado = estado_q;
  assign db_vidas  = vidas_q;

endmodule

// File: tb/tb_unidade_controle_drone.sv
// Scoreboard bench for unidade_controle_drone: the stimulus process pushes
// the hand-derived expected state/outputs per cycle, a monitor compares.
module tb_unidade_controle_drone;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       pausa = 1'b0;
  logic       colisao = 1'b0;
  logic       fim_espera = 1'b0;
  logic       fim_mapa = 1'b0;
  logic       zeraPosicoes, desloca, contaT, zeraT, pronto, ganhou, perdeu;
  logic [1:0] db_vidas;
  logic [3:0] db_estado;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] v;
    logic       zp;
    logic       ds;
    logic       ct;
    logic       zt;
    logic       pr;
    logic       g;
    logic       p;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  unidade_controle_drone #(.VIDAS(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .pausa        (pausa),
    .colisao      (colisao),
    .fim_espera   (fim_espera),
    .fim_mapa     (fim_mapa),
    .zeraPosicoes (zeraPosicoes),
    .desloca      (desloca),
    .contaT       (contaT),
    .zeraT        (zeraT),
    .pronto       (pronto),
    .ganhou       (ganhou),
    .perdeu       (perdeu),
    .db_vidas     (db_vidas),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  // Output table for each state code, written out from the state list.
  function automatic obs_t mk(input int st, input int v);
    obs_t o;
    o.st = 4'(st);
    o.v  = 2'(v);
    o.zp = (st == 1);
    o.ds = (st == 3);
    o.ct = (st == 2);
    o.zt = (st == 1) || (st == 5);
    o.pr = (st == 6) || (st == 7);
    o.g  = (st == 6);
    o.p  = (st == 7);
    return o;
  endfunction

  // One clock: drive inputs at the falling edge, queue the expectation
  // for the state entered at the following rising edge.
  task automatic cyc(input string tag, input bit rs, input bit ini, input bit pa,
                     input bit fe, input bit col, input bit fm,
                     input int st, input int v);
    @(negedge clock);
    reset      = rs;
    iniciar    = ini;
    pausa      = pa;
    fim_espera = fe;
    colisao    = col;
    fim_mapa   = fm;
    @(posedge clock);
    exp_q.push_back(mk(st, v));
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag, input int st, input int v);
    cyc(tag, 0, 0, 0, 0, 0, 0, st, v);
  endtask

  // fim_espera in ESPERA -> DESLOCA, CARREGA, VERIFICA, then the outcome.
  task automatic move(input string tag, input bit col, input bit fm,
                      input int v_now, input int st_end, input int v_end);
    cyc({tag, "_desloca"}, 0, 0, 0, 1, 0, 0, 3, v_now);
    idle({tag, "_carrega"}, 4, v_now);
    idle({tag, "_verifica"}, 5, v_now);
    cyc({tag, "_result"}, 0, 0, 0, 0, col, fm, st_end, v_end);
  endtask

  // Monitor: every cycle the DUT presents its registered outputs.
  initial begin
    obs_t  e;
    obs_t  a;
    string t;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {db_estado, db_vidas, zeraPosicoes, desloca, contaT, zeraT,
             pronto, ganhou, perdeu};
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got estado=%0d vidas=%0d zp=%b ds=%b ct=%b zt=%b pr=%b g=%b p=%b, want estado=%0d vidas=%0d zp=%b ds=%b ct=%b zt=%b pr=%b g=%b p=%b",
                   t, a.st, a.v, a.zp, a.ds, a.ct, a.zt, a.pr, a.g, a.p,
                   e.st, e.v, e.zp, e.ds, e.ct, e.zt, e.pr, e.g, e.p);
        end
      end
    end
  end

  initial begin
    // Start sequence
    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 3);
    idle("inicial_hold", 0, 3);
    cyc("start", 0, 1, 0, 0, 0, 0, 1, 3);
    idle("prep_to_espera", 2, 3);
    idle("espera_hold", 2, 3);

    // Clean move
    move("clean", 0, 0, 3, 2, 3);
    idle("clean_wait", 2, 3);

    // Lives: three collisions
    move("hit1", 1, 0, 3, 1, 2);
    idle("hit1_prep", 2, 2);
    move("hit2", 1, 0, 2, 1, 1);
    idle("hit2_prep", 2, 1);
    move("hit3", 1, 0, 1, 7, 0);
    idle("derrota_hold", 7, 0);
    cyc("derrota_pausa_ignored", 0, 0, 1, 1, 0, 0, 7, 0);
    cyc("restart_lose", 0, 1, 0, 0, 0, 0, 1, 3);
    idle("restart_lose_prep", 2, 3);

    // Win, then collision beats fim_mapa
    move("win", 0, 1, 3, 6, 3);
    cyc("vitoria_pausa_ignored", 0, 0, 1, 0, 0, 0, 6, 3);
    cyc("restart_win", 0, 1, 0, 0, 0, 0, 1, 3);
    idle("restart_win_prep", 2, 3);
    cyc("espera_iniciar_ignored", 0, 1, 0, 0, 0, 0, 2, 3);
    move("hit_a", 1, 0, 3, 1, 2);
    idle("hit_a_prep", 2, 2);
    move("prio", 1, 1, 2, 1, 1);
    idle("prio_prep", 2, 1);

    // Pause with fim_espera held
    cyc("pause_in", 0, 0, 1, 0, 0, 0, 8, 1);
    for (int i = 0; i < 20; i++) begin
      cyc("paused_fe", 0, 0, 0, 1, 0, 0, 8, 1);
    end
    cyc("pause_out", 0, 0, 1, 0, 0, 0, 2, 1);
    idle("after_pause", 2, 1);

    // Reset dominance from CARREGA
    cyc("rd_desloca", 0, 0, 0, 1, 0, 0, 3, 1);
    idle("rd_carrega", 4, 1);
    cyc("reset_dominance", 1, 1, 0, 0, 0, 0, 0, 3);
    idle("post_reset", 0, 3);

    // Illegal state code recovers to INICIAL
    @(negedge clock);
    force dut.estado_q = 4'd12;
    #1;
    release dut.estado_q;
    @(posedge clock);
    exp_q.push_back(mk(0, 3));
    tag_q.push_back("illegal_recover");
    idle("illegal_after", 0, 3);

    // Drain the scoreboard with a bound
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clock);
    end
    @(negedge clock);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
